// File: rtl/mil_tx_if.sv
// Word-queue handshake between the SPI-side word source and the MIL-STD-1553 transmitter.
// in_data packs {WordType[1:0], dataWord[15:0]}.
interface mil_tx_if;
  logic [17:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mil_transmitter.sv
// MIL-STD-1553 Manchester II transmitter: one 18-bit MilData word becomes a 40-half-bit frame
// (sync, 16 data bits, parity) on a differential line pair, with back-to-back word support.
module mil_transmitter #(
  parameter int CLK_PER_HALFBIT = 12
) (
  input  logic      clk,
  input  logic      rst,
  mil_tx_if.slave   bus,
  output logic      line_p,
  output logic      line_n,
  output logic      busy
);

  localparam int             TW        = $clog2(CLK_PER_HALFBIT);
  localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_PER_HALFBIT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    hb_q, hb_d;
  logic [15:0]   word_q, word_d;
  logic [1:0]    type_q, type_d;
  logic          line_p_d, line_n_d, busy_d;
  logic          half_end, last_clk, accept;

  assign half_end     = (tick_q == TICK_LAST);
  assign last_clk     = (state_q == PARITY) && (hb_q == 6'd39) && half_end;
  assign bus.in_ready = (state_q == IDLE) || last_clk;
  assign accept       = bus.in_valid && bus.in_ready;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments for every flop so all registers update from the same pre-edge values.
      state_q <= IDLE;
      tick_q  <= '0;
      hb_q    <= '0;
      word_q  <= '0;
      type_q  <= '0;
      line_p  <= 1'b0;
      line_n  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      hb_q    <= hb_d;
      word_q  <= word_d;
      type_q  <= type_d;
      line_p  <= line_p_d;
      line_n  <= line_n_d;
      busy    <= busy_d;
    end
  end

  // Next-state logic: counters advance per clk, half-bit index per half-bit period.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    tick_d  = tick_q;
    hb_d    = hb_q;
    word_d  = word_q;
    type_d  = type_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SYNC;
          tick_d  = '0;
          hb_d    = '0;
          word_d  = bus.in_data[15:0];
          type_d  = bus.in_data[17:16];
        end
      end
      default: begin
        if (!half_end) begin
          tick_d = tick_q + 1'b1;
        end else begin
          tick_d = '0;
          hb_d   = hb_q + 6'd1;
          if (state_q == SYNC && hb_q == 6'd5)        state_d = DATA;
          else if (state_q == DATA && hb_q == 6'd37)  state_d = PARITY;
          else if (state_q == PARITY && hb_q == 6'd39) begin
            hb_d = '0;
            if (accept) begin
              state_d = SYNC;
              word_d  = bus.in_data[15:0];
              type_d  = bus.in_data[17:16];
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  // Output logic, evaluated on next-state values so the registered lines change on the
  // accepting edge itself. Even half-bit indices are the first half of a Manchester bit.
  logic       level;
  logic       parity;
  logic [4:0] bit_no;

  always_comb begin
    level    = 1'b0;
    line_p_d = 1'b0;
    line_n_d = 1'b0;
    busy_d   = 1'b0;
    bit_no   = 5'(hb_d >> 1);
    // Odd parity over 17 bits; the *ERR types (WordType[0]=0) invert it on purpose.
    parity   = (~^word_d) ^ ~type_d[0];
    unique case (state_d)
      IDLE:    level = 1'b0;
      SYNC:    level = (hb_d < 6'd3) ^ type_d[1];
      DATA:    level = word_d[4'(5'd18 - bit_no)] ^ hb_d[0];
      PARITY:  level = parity ^ hb_d[0];
      default: level = 1'b0;
    endcase
    if (state_d != IDLE) begin
      busy_d   = 1'b1;
      line_p_d = level;
      line_n_d = ~level;
    end
  end

endmodule

// File: doc/mil_transmitter.md
Name: mil_transmitter

Overview:
- Encodes one MilData word (2-bit WordType plus 16-bit dataWord) into a MIL-STD-1553 Manchester II bi-phase frame.
- Drives a differential transceiver pair (line_p/line_n).
- Sits between the SPI-side word queue and the bus transceiver. It is the send-side counterpart of the line receiver/decoder.
- Supports back-to-back words and deliberate parity-error injection for the *ERR word types.

Parameters:
- CLK_PER_HALFBIT, 12, clk cycles per 0.5 µs half-bit (clk = 24 MHz gives 1 Mbit/s); must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_data  in  18  MilData packed: [17:16] WordType (00 WSERVERR, 01 WSERV, 10 WDATAERR, 11 WDATA), [15:0] dataWord
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts a word this cycle
- line_p  out  1  positive line drive
- line_n  out  1  negative line drive
- busy  out  1  frame in progress

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: line_p=0, line_n=0, busy=0, state=IDLE, counters=0. in_ready=1 once out of reset. Reset mid-frame aborts immediately; both lines return to 0.
- Handshake: a word is accepted when in_valid && in_ready. in_data is latched on acceptance, so it may change afterwards.
- in_ready=1 in IDLE. It is also 1 on the last clk of the final parity half-bit; acceptance there starts a contiguous next word with no gap. It is 0 at all other times.
- Latency: first line drive appears on the clk edge after acceptance. Outputs are registered.
- Line encoding per half-bit: "high" = line_p=1, line_n=0; "low" = line_p=0, line_n=1; idle = both 0. line_p and line_n are never 1 together.
- The frame is 40 half-bits = 40*CLK_PER_HALFBIT clk cycles (20 µs).
- State SYNC, 6 half-bits:
  - WSERV/WSERVERR: 3 high then 3 low.
  - WDATA/WDATAERR: 3 low then 3 high.
- State DATA, 32 half-bits, bit 15 first. Bit 1 = high then low; bit 0 = low then high.
- State PARITY, 2 half-bits, same encoding as a data bit.
  - Parity bit P = ~^dataWord, giving odd parity over the 17 bits.
  - For WSERVERR/WDATAERR, P is inverted (error injection).
- Transitions:
  - IDLE -> SYNC on acceptance.
  - SYNC -> DATA after the 6th half-bit.
  - DATA -> PARITY after the 32nd half-bit.
  - PARITY -> SYNC if a word is accepted on its last clk; otherwise PARITY -> IDLE.
- Counters: tick counter runs 0..CLK_PER_HALFBIT-1, width $clog2(CLK_PER_HALFBIT). Half-bit counter runs 0..39 within a frame, 6 bits. Both reset to 0 on every acceptance.
- busy=1 from the cycle after acceptance through the last parity half-bit. It stays 1 continuously across back-to-back words. Otherwise busy=0.
- in_valid dropping while not ready has no effect. in_valid held high during a frame is not consumed until in_ready.

Test Plan (CLK_PER_HALFBIT=2, so each half-bit = 2 clks, frame = 80 clks):
- Reset release, in_valid=0 for 100 clks -> in_ready=1, busy=0, line_p=line_n=0 throughout.
- WSERV 0x0000 -> from the next clk: line_p high 6 clks, line_n high 6 clks; then 16 × (line_n 2, line_p 2); then parity 1 (line_p 2, line_n 2); then idle at clk 81; busy high for exactly 80 clks.
- WDATA 0x0001 -> sync starts with line_n high 6 clks, then line_p high 6 clks; 15 zero bits then one 1 bit; parity 0 (line_n then line_p). WDATA 0xFFFF -> parity 1.
- WDATAERR 0x0001 -> identical to WDATA 0x0001 except parity half-bits become line_p then line_n (P=1).
- Two words with in_valid held high (WSERV 0xA5A5 then WDATA 0x5A5A) -> in_ready pulses 1 clk on the last parity clk; second sync begins on the next clk; busy stays high for 160 clks; no idle cycle between frames.
- Assert rst at clk 30 of a frame -> line_p=line_n=0 and busy=0 asynchronously. After release, a new WSERV 0xFFFF is accepted and transmits a full, correct 80-clk frame.
- All scenarios -> checker asserts line_p & line_n is never 1.
